// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a req/ready
// memory handshake, an illegal-instruction HALT trap and a retired counter.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        aluout_write,
  output logic        pc_src,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        retire;
  logic [31:0] count;
  logic        legal;
  logic        br_legal;
  logic        br_taken;

  // Opcode legality and branch condition decode
  always_comb begin
    legal    = 1'b0;
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = ~alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = ~alu_lt;
      default: br_legal = 1'b0;
    endcase
  end

  // Output strobes and next state; everything is forced low while reset is low
  always_comb begin
    ALUOp        = '0;
    alu_src_a    = '0;
    alu_src_b    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    aluout_write = 1'b0;
    pc_src       = 1'b0;
    wb_sel       = '0;
    halted       = 1'b0;
    retire       = 1'b0;
    state_nx     = state;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a    = 2'b01;
          alu_src_b    = 2'b10;
          aluout_write = 1'b1;
          state_nx     = legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          case (opcode)
            OP_R: begin
              alu_src_a = 2'b10; alu_src_b = 2'b00; ALUOp = 2'b10;
              aluout_write = 1'b1; state_nx = S_WB;
            end
            OP_I: begin
              alu_src_a = 2'b10; alu_src_b = 2'b10; ALUOp = 2'b10;
              aluout_write = 1'b1; state_nx = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 2'b10; alu_src_b = 2'b10; ALUOp = 2'b00;
              aluout_write = 1'b1; state_nx = S_MEM;
            end
            OP_LUI: begin
              alu_src_a = 2'b11; alu_src_b = 2'b10; ALUOp = 2'b11;
              aluout_write = 1'b1; state_nx = S_WB;
            end
            OP_AUIPC: begin
              alu_src_a = 2'b01; alu_src_b = 2'b10; ALUOp = 2'b00;
              aluout_write = 1'b1; state_nx = S_WB;
            end
            OP_BRANCH: begin
              alu_src_a = 2'b10; alu_src_b = 2'b00; ALUOp = 2'b01;
              if (br_legal) begin
                pc_write = br_taken;
                pc_src   = br_taken;
                retire   = 1'b1;
                state_nx = S_FETCH;
              end else begin
                state_nx = S_HALT;
              end
            end
            OP_JAL: begin
              // PC takes the ALUOut target while the register file captures PC+4
              ALUOp = 2'b11; pc_write = 1'b1; pc_src = 1'b1;
              reg_write = 1'b1; wb_sel = 2'b10;
              retire = 1'b1; state_nx = S_FETCH;
            end
            default: state_nx = S_HALT;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              retire   = 1'b1;
              state_nx = S_FETCH;
            end else begin
              state_nx = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
          retire    = 1'b1;
          state_nx  = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: state_nx = S_FETCH;
      endcase
    end
  end

  // State register and retired-instruction counter (wraps naturally)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
      count <= '0;
    end else begin
      state <= state_nx;
      if (retire) count <= count + 32'd1;
    end
  end

  assign instret = reset ? count : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes a
// hand-computed per-cycle output vector; a monitor pops and compares at negedge.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_zero;
  logic        alu_lt;
  logic        mem_ready;
  logic [1:0]  ALUOp;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        aluout_write;
  logic        pc_src;
  logic [1:0]  wb_sel;
  logic        halted;
  logic [31:0] instret;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .aluout_write(aluout_write), .pc_src(pc_src), .wb_sel(wb_sel),
    .halted(halted), .instret(instret)
  );

  // Bit order: ALUOp,a,b,req,we,addr_sel,ir,pc,reg,aluout,pc_src,wb_sel,halted
  function automatic logic [16:0] mk(input logic [1:0] op, input logic [1:0] a,
                                     input logic [1:0] b, input logic rq, input logic we,
                                     input logic as, input logic ir, input logic pw,
                                     input logic rw, input logic aw, input logic ps,
                                     input logic [1:0] wb, input logic h);
    return {op, a, b, rq, we, as, ir, pw, rw, aw, ps, wb, h};
  endfunction

  localparam logic [16:0] V_ZERO = '0;
  localparam logic [16:0] V_FW  = mk(2'b00,2'b00,2'b01,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_FR  = mk(2'b00,2'b00,2'b01,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_D   = mk(2'b00,2'b01,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_ER  = mk(2'b10,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_ELS = mk(2'b00,2'b10,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_ELU = mk(2'b11,2'b11,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_EBT = mk(2'b01,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,1'b0);
  localparam logic [16:0] V_EBN = mk(2'b01,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_EJ  = mk(2'b11,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,2'b10,1'b0);
  localparam logic [16:0] V_ML  = mk(2'b00,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_MS  = mk(2'b00,2'b00,2'b00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_WA  = mk(2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0);
  localparam logic [16:0] V_WL  = mk(2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,1'b0);
  localparam logic [16:0] V_H   = mk(2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1);

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JALR = 7'b1100111;

  typedef struct {
    string       name;
    logic [16:0] v;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = '0;
  logic [16:0] got;

  assign got = {ALUOp, alu_src_a, alu_src_b, mem_req, mem_we, mem_addr_sel,
                ir_write, pc_write, reg_write, aluout_write, pc_src, wb_sel, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the expected outputs for that cycle
  task automatic step(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                      input logic rdy, input logic rst, input logic [16:0] v,
                      input logic ret);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = opc;
    funct3    = f3;
    mem_ready = rdy;
    reset     = rst;
    e.name = nm;
    e.v    = v;
    e.cnt  = rst ? exp_cnt : 32'd0;
    q.push_back(e);
    if (!rst) exp_cnt = '0;
    else if (ret) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Monitor: compare the DUT outputs against the scoreboard every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (got !== e.v || instret !== e.cnt) begin
          errors++;
          $display("FAIL %s: got outputs=%b instret=%0d, expected outputs=%b instret=%0d",
                   e.name, got, instret, e.v, e.cnt);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; opcode = ADD; funct3 = 3'b000;
    alu_zero = 1'b1; alu_lt = 1'b0; mem_ready = 1'b1;

    step("rst_a", ADD, 3'b000, 1'b1, 1'b0, V_ZERO, 1'b0);
    step("rst_b", ADD, 3'b000, 1'b1, 1'b0, V_ZERO, 1'b0);

    step("add_fetch",  ADD, 3'b000, 1'b1, 1'b1, V_FR, 1'b0);
    step("add_decode", ADD, 3'b000, 1'b1, 1'b1, V_D,  1'b0);
    step("add_exec",   ADD, 3'b000, 1'b1, 1'b1, V_ER, 1'b0);
    step("add_wb",     ADD, 3'b000, 1'b1, 1'b1, V_WA, 1'b1);

    step("lw_fwait1",  LW, 3'b010, 1'b0, 1'b1, V_FW,  1'b0);
    step("lw_fwait2",  LW, 3'b010, 1'b0, 1'b1, V_FW,  1'b0);
    step("lw_fready",  LW, 3'b010, 1'b1, 1'b1, V_FR,  1'b0);
    step("lw_decode",  LW, 3'b010, 1'b1, 1'b1, V_D,   1'b0);
    step("lw_exec",    LW, 3'b010, 1'b1, 1'b1, V_ELS, 1'b0);
    step("lw_mwait1",  LW, 3'b010, 1'b0, 1'b1, V_ML,  1'b0);
    step("lw_mwait2",  LW, 3'b010, 1'b0, 1'b1, V_ML,  1'b0);
    step("lw_mready",  LW, 3'b010, 1'b1, 1'b1, V_ML,  1'b0);
    step("lw_wb",      LW, 3'b010, 1'b1, 1'b1, V_WL,  1'b1);

    step("beq_fetch",  BR, 3'b000, 1'b1, 1'b1, V_FR,  1'b0);
    step("beq_decode", BR, 3'b000, 1'b1, 1'b1, V_D,   1'b0);
    step("beq_exec",   BR, 3'b000, 1'b1, 1'b1, V_EBT, 1'b1);

    step("bne_fetch",  BR, 3'b001, 1'b1, 1'b1, V_FR,  1'b0);
    step("bne_decode", BR, 3'b001, 1'b1, 1'b1, V_D,   1'b0);
    step("bne_exec",   BR, 3'b001, 1'b1, 1'b1, V_EBN, 1'b1);

    step("jal_fetch",  JAL, 3'b000, 1'b1, 1'b1, V_FR, 1'b0);
    step("jal_decode", JAL, 3'b000, 1'b1, 1'b1, V_D,  1'b0);
    step("jal_exec",   JAL, 3'b000, 1'b1, 1'b1, V_EJ, 1'b1);

    step("sw_fetch",   SW, 3'b010, 1'b1, 1'b1, V_FR,   1'b0);
    step("sw_decode",  SW, 3'b010, 1'b1, 1'b1, V_D,    1'b0);
    step("sw_exec",    SW, 3'b010, 1'b1, 1'b1, V_ELS,  1'b0);
    step("sw_mwait",   SW, 3'b010, 1'b0, 1'b1, V_MS,   1'b0);
    step("sw_reset",   SW, 3'b010, 1'b1, 1'b0, V_ZERO, 1'b0);
    step("post_rst",   SW, 3'b010, 1'b0, 1'b1, V_FW,   1'b0);

    step("jalr_fetch",  JALR, 3'b000, 1'b1, 1'b1, V_FR, 1'b0);
    step("jalr_decode", JALR, 3'b000, 1'b1, 1'b1, V_D,  1'b0);
    step("halt_1",      JALR, 3'b000, 1'b1, 1'b1, V_H,  1'b0);
    step("halt_2",      JALR, 3'b000, 1'b1, 1'b1, V_H,  1'b0);
    step("halt_3",      JALR, 3'b000, 1'b1, 1'b1, V_H,  1'b0);
    step("rst_c",       JALR, 3'b000, 1'b1, 1'b0, V_ZERO, 1'b0);

    step("lui_fetch",  LUI, 3'b000, 1'b1, 1'b1, V_FR,  1'b0);
    step("lui_decode", LUI, 3'b000, 1'b1, 1'b1, V_D,   1'b0);
    step("lui_exec",   LUI, 3'b000, 1'b1, 1'b1, V_ELU, 1'b0);
    step("lui_wb",     LUI, 3'b000, 1'b1, 1'b1, V_WA,  1'b1);

    step("badbr_fetch",  BR, 3'b010, 1'b1, 1'b1, V_FR,  1'b0);
    step("badbr_decode", BR, 3'b010, 1'b1, 1'b1, V_D,   1'b0);
    step("badbr_exec",   BR, 3'b010, 1'b1, 1'b1, V_EBN, 1'b0);
    step("badbr_halt1",  BR, 3'b010, 1'b1, 1'b1, V_H,   1'b0);
    step("badbr_halt2",  BR, 3'b010, 1'b1, 1'b1, V_H,   1'b0);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the RV32I core: walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes, mux selects and the 2-bit `ALUOp` consumed by `ALUController`. Sits between the instruction register/decoder and the shared ALU/memory datapath. Handles memory wait states through a req/ready handshake and keeps a retired-instruction counter.

## Interface
- No parameters (fixed RV32I subset).

- `clk`  in  1  sole clock, all state on rising edge
- `reset`  in  1  synchronous, active-low
- `opcode`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `alu_zero`  in  1  ALU result == 0
- `alu_lt`  in  1  ALU signed less-than flag
- `mem_ready`  in  1  memory completes current access this cycle
- `ALUOp`  out  2  00 add (LW/SW/AUIPC/PC math), 01 branch, 10 R/I, 11 JAL/LUI
- `alu_src_a`  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- `alu_src_b`  out  2  00 rs2, 01 const 4, 10 imm
- `mem_req`  out  1  access request
- `mem_we`  out  1  store when 1
- `mem_addr_sel`  out  1  0 PC, 1 ALUOut
- `ir_write`, `pc_write`, `reg_write`, `aluout_write`  out  1 each  register enables
- `pc_src`  out  1  0 ALU result, 1 ALUOut
- `wb_sel`  out  2  00 ALUOut, 01 mem data, 10 PC
- `halted`  out  1  illegal instruction trapped
- `instret`  out  32  retired-instruction count

## Operation
- Reset low at an edge: state <= FETCH, instret <= 0. While reset is low, all outputs are forced to 0 (combinational gating), including mid-access `mem_req`.
- Outputs decode from state, opcode and mem_ready; unlisted outputs are 0.
- FETCH: mem_req=1, mem_addr_sel=0, alu_src_a=00, alu_src_b=01, ALUOp=00. On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE; otherwise hold.
- DECODE: alu_src_a=01, alu_src_b=10, ALUOp=00, aluout_write=1 (branch/JAL target). Legal opcode goes to EXEC, otherwise HALT.
- Legal opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 0110111 LUI, 0010111 AUIPC.
- EXEC by class:
  - R: a=10, b=00, ALUOp=10, aluout_write, go to WB.
  - I: a=10, b=10, ALUOp=10, aluout_write, go to WB.
  - LOAD/STORE: a=10, b=10, ALUOp=00, aluout_write, go to MEM.
  - LUI: a=11, b=10, ALUOp=11, aluout_write, go to WB.
  - AUIPC: a=01, b=10, ALUOp=00, aluout_write, go to WB.
  - BRANCH: a=10, b=00, ALUOp=01.
    - Taken: funct3 000 zero; 001 !zero; 100 lt; 101 !lt.
    - If taken: pc_write=1, pc_src=1.
    - instret++, go to FETCH.
    - Any other funct3 goes to HALT with no pc_write.
  - JAL: ALUOp=11, pc_write=1, pc_src=1, reg_write=1, wb_sel=10. The register file captures PC+4 at the same edge PC takes the target. instret++, go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). Hold until mem_ready.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE does instret++ and goes to FETCH.
- WB: reg_write=1; wb_sel=01 for LOAD, else 00. instret++, go to FETCH.
- HALT: halted=1, all strobes 0, absorbing until reset.
- instret wraps 0xFFFF_FFFF to 0.

## Timing
- Cycles per instruction with zero wait states (mem_ready high in the first request cycle):
  - BRANCH, JAL: 3.
  - R, I, LUI, AUIPC, STORE: 4.
  - LOAD: 5.
- Each idle mem_ready cycle adds exactly one cycle.
- mem_req, mem_we and mem_addr_sel are stable from request until the ready cycle inclusive; mem_req drops the cycle after.
- Write enables (ir_write, pc_write in FETCH) assert only in the mem_ready cycle.
- instret updates at the retiring edge and is visible the next cycle.
- The reset edge wins over any simultaneous mem_ready or retire.

## Test plan
- Reset held 2 cycles with mem_ready=1 → all outputs 0, instret=0. First cycle after release: mem_req=1, ALUOp=00, alu_src_b=01.
- ADD (0110011/000), mem_ready tied 1 → states F,D,E,W (4 cycles); ALUOp=10 in EXEC; reg_write=1, wb_sel=00 in WB; instret=1.
- LW with 2 wait cycles on both fetch and data access → 9 cycles; mem_req high 3 cycles each time; ir_write one pulse; reg_write with wb_sel=01; instret=1.
- BEQ alu_zero=1 → pc_write=1, pc_src=1 in EXEC. BNE with alu_zero=1 → pc_write=0. Both 3 cycles, instret +1 each.
- JAL → EXEC asserts pc_write, reg_write, wb_sel=10, ALUOp=11 in the same cycle. Opcode 1100111 (JALR) → HALT, halted=1, no further mem_req until reset.
- SW with reset asserted in the middle MEM wait cycle → mem_req=0 the same cycle, no retire; after release, state is FETCH and instret=0.
